// File: rtl/period_abs_sum_ctrl_if.sv
// Bus bundle for period_abs_sum_ctrl: input word stream, abs-sum datapath link,
// period result stream and control inputs.
interface period_abs_sum_ctrl_if #(
    parameter int unsigned ACC_W = 32
);
    logic             Enable;
    logic [ACC_W-1:0] Threshold;

    logic [127:0]     InData;
    logic             InValid;
    logic             InReady;

    logic [127:0]     DpData;
    logic [31:0]      DpAbsSum;

    logic [ACC_W-1:0] OutSum;
    logic             OutDetect;
    logic             OutValid;
    logic             OutReady;

    logic [15:0]      PeriodCnt;

    // Environment side: sample producer, abs-sum datapath and result consumer
    modport master (
        output Enable, Threshold, InData, InValid, DpAbsSum, OutReady,
        input  InReady, DpData, OutSum, OutDetect, OutValid, PeriodCnt
    );

    // Controller side
    modport slave (
        input  Enable, Threshold, InData, InValid, DpAbsSum, OutReady,
        output InReady, DpData, OutSum, OutDetect, OutValid, PeriodCnt
    );
endinterface

// File: rtl/period_abs_sum_ctrl.sv
// Period abs-sum controller: feeds one 128-bit word per cycle to an external
// abs-sum datapath, accumulates WORDS_PER_PERIOD results and reports the period
// total with a strict threshold compare on a valid/ready result port.
module period_abs_sum_ctrl #(
    parameter int unsigned WORDS_PER_PERIOD = 4,
    parameter int unsigned ACC_W            = 32
) (
    input logic                  clk,
    input logic                  rst,
    period_abs_sum_ctrl_if.slave bus
);

    localparam int unsigned CNT_W    = 16;
    localparam int unsigned DATA_W   = 128;
    localparam int unsigned PCNT_W   = 16;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ACCUM = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;

    logic [DATA_W-1:0]   r_dp_data;
    logic                r_pipe_valid;
    logic                r_pipe_first;
    logic                r_pipe_last;
    logic [CNT_W-1:0]    r_word_cnt;
    logic [ACC_W-1:0]    r_acc;
    logic [ACC_W-1:0]    r_thr;
    logic [ACC_W-1:0]    r_out_sum;
    logic                r_out_detect;
    logic                r_out_valid;
    logic [PCNT_W-1:0]   r_period_cnt;

    logic                w_in_ready;
    logic                w_accept;
    logic                w_word_first;
    logic                w_word_last;
    logic                w_pipe_done;
    logic                w_out_take;
    logic [ACC_W-1:0]    w_abs_ext;
    logic [ACC_W-1:0]    w_acc_next;

    // Word position, pipe completion and result handshake decodes
    always_comb begin
        w_accept     = bus.InValid & w_in_ready;
        w_word_first = (r_word_cnt == '0);
        w_word_last  = (r_word_cnt == CNT_W'(WORDS_PER_PERIOD - 1));
        w_pipe_done  = r_pipe_valid & r_pipe_last;
        w_out_take   = r_out_valid & bus.OutReady;
        w_abs_ext    = ACC_W'(bus.DpAbsSum);
        w_acc_next   = r_pipe_first ? w_abs_ext : (r_acc + w_abs_ext);
    end

    // State register
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    // Next-state and InReady; InReady is forced low during the reset cycle
    always_comb begin
        w_state_next = r_state;
        w_in_ready   = 1'b0;
        unique case (r_state)
            ST_IDLE: begin
                w_in_ready = bus.Enable;
                if (bus.InValid && bus.Enable) begin
                    w_state_next = ST_ACCUM;
                end
            end
            ST_ACCUM: begin
                // Stall while the closing word of the period is in the pipe
                w_in_ready = ~(r_pipe_valid & r_pipe_last);
                if (w_pipe_done) begin
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_out_take) begin
                    w_state_next = ST_IDLE;
                end
            end
            default: begin
                w_state_next = ST_IDLE;
            end
        endcase
        if (rst) begin
            w_in_ready = 1'b0;
        end
    end

    // Input stage: capture accepted word toward the datapath and track position
    always_ff @(posedge clk) begin
        if (rst) begin
            r_dp_data    <= '0;
            r_pipe_valid <= 1'b0;
            r_pipe_first <= 1'b0;
            r_pipe_last  <= 1'b0;
            r_word_cnt   <= '0;
        end else if (w_accept) begin
            r_dp_data    <= bus.InData;
            r_pipe_valid <= 1'b1;
            r_pipe_first <= w_word_first;
            r_pipe_last  <= w_word_last;
            r_word_cnt   <= w_word_last ? '0 : (r_word_cnt + CNT_W'(1));
        end else begin
            r_pipe_valid <= 1'b0;
            r_pipe_first <= 1'b0;
            r_pipe_last  <= 1'b0;
        end
    end

    // Threshold is frozen when a period opens so mid-period changes are ignored
    always_ff @(posedge clk) begin
        if (rst) begin
            r_thr <= '0;
        end else if (w_accept && (r_state == ST_IDLE)) begin
            r_thr <= bus.Threshold;
        end
    end

    // Accumulator: first word of a period loads, later words add
    always_ff @(posedge clk) begin
        if (rst) begin
            r_acc <= '0;
        end else if (r_pipe_valid) begin
            r_acc <= w_acc_next;
        end
    end

    // Result register: loaded when the last word lands, held until consumed
    always_ff @(posedge clk) begin
        if (rst) begin
            r_out_sum    <= '0;
            r_out_detect <= 1'b0;
            r_out_valid  <= 1'b0;
        end else if (w_pipe_done) begin
            r_out_sum    <= w_acc_next;
            r_out_detect <= (w_acc_next > r_thr);
            r_out_valid  <= 1'b1;
        end else if (w_out_take) begin
            r_out_valid  <= 1'b0;
        end
    end

    // Delivered-period counter, wraps naturally at 16 bits
    always_ff @(posedge clk) begin
        if (rst) begin
            r_period_cnt <= '0;
        end else if (w_out_take) begin
            r_period_cnt <= r_period_cnt + PCNT_W'(1);
        end
    end

    assign bus.InReady   = w_in_ready;
    assign bus.DpData    = r_dp_data;
    assign bus.OutSum    = r_out_sum;
    assign bus.OutDetect = r_out_detect;
    assign bus.OutValid  = r_out_valid;
    assign bus.PeriodCnt = r_period_cnt;

endmodule

// File: tb/tb_period_abs_sum_ctrl.sv
// Self-checking bench for period_abs_sum_ctrl (WORDS_PER_PERIOD=4, ACC_W=32).
module tb_period_abs_sum_ctrl;

    localparam int unsigned ACC_W  = 32;
    localparam int          TO_LIM = 40;

    typedef struct {
        logic [3:0][127:0] words;
        logic [31:0]       thr;
        logic [31:0]       thr_mid;
        logic [31:0]       exp_sum;
        logic              exp_det;
    } vec_t;

    typedef struct {
        logic [31:0] sum;
        logic        det;
    } exp_t;

    logic clk = 1'b0;
    logic rst = 1'b1;

    int   checks  = 0;
    int   errors  = 0;
    int   exp_cnt = 0;
    exp_t sb[$];
    vec_t vecs[6];

    period_abs_sum_ctrl_if #(.ACC_W(ACC_W)) bus ();

    period_abs_sum_ctrl #(
        .WORDS_PER_PERIOD(4),
        .ACC_W           (ACC_W)
    ) dut (
        .clk(clk),
        .rst(rst),
        .bus(bus)
    );

    always #5 clk = ~clk;

    function automatic logic [127:0] fill(input logic [7:0] b);
        return {16{b}};
    endfunction

    function automatic logic [31:0] abs_sum(input logic [127:0] w);
        int acc;
        int v;
        acc = 0;
        for (int i = 0; i < 16; i++) begin
            v = int'($signed(w[8*i +: 8]));
            acc += (v < 0) ? -v : v;
        end
        return 32'(acc);
    endfunction

    // External combinational abs-sum datapath
    always_comb bus.DpAbsSum = abs_sum(bus.DpData);

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] expv);
        checks++;
        if (act !== expv) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, expv);
        end
    endtask

    // Present one word and return just after the edge that accepts it
    task automatic send_word(input logic [127:0] d);
        int n;
        n = 0;
        bus.InData  = d;
        bus.InValid = 1'b1;
        @(negedge clk);
        while (!bus.InReady && n < TO_LIM) begin
            @(negedge clk);
            n++;
        end
        if (!bus.InReady) begin
            checks++;
            errors++;
            $display("FAIL send_word: InReady stuck low got 0 expected 1");
        end
        @(posedge clk);
        #1;
        bus.InValid = 1'b0;
    endtask

    // Called at a negedge; waits for a result, compares against the scoreboard
    task automatic collect(input string name);
        int   n;
        exp_t e;
        n = 0;
        while (!bus.OutValid && n < TO_LIM) begin
            @(negedge clk);
            n++;
        end
        if (!bus.OutValid) begin
            checks++;
            errors++;
            $display("FAIL %s: OutValid timeout got 0 expected 1", name);
            return;
        end
        if (sb.size() == 0) begin
            checks++;
            errors++;
            $display("FAIL %s: unexpected result got %0d expected none", name, bus.OutSum);
            return;
        end
        e = sb.pop_front();
        chk({name, " sum"}, 128'(bus.OutSum), 128'(e.sum));
        chk({name, " detect"}, 128'(bus.OutDetect), 128'(e.det));
        chk({name, " cnt_pre"}, 128'(bus.PeriodCnt), 128'(exp_cnt));
        if (bus.OutReady) begin
            @(posedge clk);
            #1;
            @(negedge clk);
            exp_cnt = (exp_cnt + 1) & 16'hFFFF;
            chk({name, " valid_drop"}, 128'(bus.OutValid), 128'(0));
            chk({name, " cnt_post"}, 128'(bus.PeriodCnt), 128'(exp_cnt));
        end
    endtask

    task automatic run_period(input vec_t v);
        exp_t e;
        e.sum = v.exp_sum;
        e.det = v.exp_det;
        sb.push_back(e);
        bus.Threshold = v.thr;
        for (int w = 0; w < 4; w++) begin
            send_word(v.words[w]);
            if (w == 0) bus.Threshold = v.thr_mid;
        end
        @(negedge clk);
    endtask

    initial begin
        logic [127:0] mixed;
        exp_t         e;
        logic [31:0]  held;

        bus.Enable    = 1'b1;
        bus.Threshold = 32'd100;
        bus.InData    = '0;
        bus.InValid   = 1'b0;
        bus.OutReady  = 1'b1;

        for (int i = 0; i < 16; i++) mixed[8*i +: 8] = (i % 2 == 0) ? 8'h05 : 8'hFB;

        vecs[0] = '{words: {4{fill(8'h80)}}, thr: 32'd8191, thr_mid: 32'd8191, exp_sum: 32'd8192, exp_det: 1'b1};
        vecs[1] = '{words: {4{fill(8'h80)}}, thr: 32'd8192, thr_mid: 32'd8192, exp_sum: 32'd8192, exp_det: 1'b0};
        vecs[2] = '{words: {128'h0, 128'h0, 128'h0, mixed}, thr: 32'd100, thr_mid: 32'd0, exp_sum: 32'd80, exp_det: 1'b0};
        vecs[3] = '{words: {4{fill(8'h7F)}}, thr: 32'd8127, thr_mid: 32'd8127, exp_sum: 32'd8128, exp_det: 1'b1};
        vecs[4] = '{words: {4{fill(8'hFF)}}, thr: 32'd63, thr_mid: 32'd63, exp_sum: 32'd64, exp_det: 1'b1};
        vecs[5] = '{words: {4{fill(8'hFF)}}, thr: 32'd64, thr_mid: 32'd0, exp_sum: 32'd64, exp_det: 1'b0};

        // Reset: InReady low while rst high, everything cleared afterwards
        @(negedge clk);
        chk("rst InReady", 128'(bus.InReady), 128'(0));
        repeat (2) @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        chk("rst DpData", bus.DpData, 128'(0));
        chk("rst OutSum", 128'(bus.OutSum), 128'(0));
        chk("rst OutValid", 128'(bus.OutValid), 128'(0));
        chk("rst OutDetect", 128'(bus.OutDetect), 128'(0));
        chk("rst PeriodCnt", 128'(bus.PeriodCnt), 128'(0));
        chk("idle InReady", 128'(bus.InReady), 128'(1));
        @(posedge clk);
        #1;

        // Latency: last accept at edge t, OutValid visible in cycle t+2
        e.sum = 32'd64;
        e.det = 1'b0;
        sb.push_back(e);
        bus.Threshold = 32'd100;
        for (int w = 0; w < 4; w++) send_word(fill(8'h01));
        @(negedge clk);
        chk("lat t+1 OutValid", 128'(bus.OutValid), 128'(0));
        chk("lat t+1 InReady", 128'(bus.InReady), 128'(0));
        @(negedge clk);
        chk("lat t+2 OutValid", 128'(bus.OutValid), 128'(1));
        collect("lat");
        @(posedge clk);
        #1;

        // Table-driven periods
        for (int k = 0; k < 6; k++) begin
            run_period(vecs[k]);
            collect($sformatf("vec%0d", k));
            @(posedge clk);
            #1;
        end

        // Back-pressure: result held stable, input stalled
        bus.OutReady = 1'b0;
        e.sum = 32'd128;
        e.det = 1'b0;
        sb.push_back(e);
        bus.Threshold = 32'd200;
        for (int w = 0; w < 4; w++) send_word(fill(8'h02));
        begin
            int n;
            n = 0;
            @(negedge clk);
            while (!bus.OutValid && n < TO_LIM) begin
                @(negedge clk);
                n++;
            end
        end
        held = bus.OutSum;
        for (int k = 0; k < 5; k++) begin
            chk($sformatf("stall%0d OutSum", k), 128'(bus.OutSum), 128'(32'd128));
            chk($sformatf("stall%0d InReady", k), 128'(bus.InReady), 128'(0));
            @(negedge clk);
        end
        chk("stall OutSum held", 128'(bus.OutSum), 128'(held));
        chk("stall cnt held", 128'(bus.PeriodCnt), 128'(exp_cnt));
        bus.OutReady = 1'b1;
        collect("stall");
        chk("stall release InReady", 128'(bus.InReady), 128'(1));
        @(posedge clk);
        #1;

        // Gapped input, Enable dropped after word 2
        e.sum = 32'd192;
        e.det = 1'b1;
        sb.push_back(e);
        bus.Threshold = 32'd100;
        for (int w = 0; w < 4; w++) begin
            send_word(fill(8'h03));
            if (w == 1) bus.Enable = 1'b0;
            @(posedge clk);
            #1;
        end
        @(negedge clk);
        collect("gap_en");
        bus.InData  = fill(8'h09);
        bus.InValid = 1'b1;
        for (int k = 0; k < 4; k++) begin
            chk($sformatf("en_low%0d InReady", k), 128'(bus.InReady), 128'(0));
            @(negedge clk);
        end
        chk("en_low DpData", bus.DpData, fill(8'h03));
        bus.InValid = 1'b0;
        bus.Enable  = 1'b1;
        @(posedge clk);
        #1;

        // Reset mid-period discards the partial sum
        bus.Threshold = 32'd100;
        send_word(fill(8'h10));
        send_word(fill(8'h10));
        rst = 1'b1;
        @(negedge clk);
        chk("mid rst InReady", 128'(bus.InReady), 128'(0));
        @(posedge clk);
        #1 rst = 1'b0;
        @(negedge clk);
        exp_cnt = 0;
        chk("mid rst DpData", bus.DpData, 128'(0));
        chk("mid rst OutSum", 128'(bus.OutSum), 128'(0));
        chk("mid rst OutValid", 128'(bus.OutValid), 128'(0));
        chk("mid rst PeriodCnt", 128'(bus.PeriodCnt), 128'(0));
        @(posedge clk);
        #1;
        e.sum = 32'd128;
        e.det = 1'b1;
        sb.push_back(e);
        for (int w = 0; w < 4; w++) send_word(fill(8'h02));
        @(negedge clk);
        collect("post_rst");

        chk("sb drained", 128'(sb.size()), 128'(0));
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
